f_pc_ctrl: RTL and testbench
============================

Name: f_pc_ctrl

Overview:
Fetch-stage sequencer for the MIPS pipeline. It owns the F-stage PC register and the F/D boundary registers. It selects the next PC (sequential, branch/jump target, ERET return, exception entry, stall hold) and classifies the fetch address for AdEL, suppressing the check for the wrong-path slot behind ERET. It sits between the IM address port, the D-stage branch unit and CP0; its D-side outputs feed the D-stage exception chain.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
EXC_ENTRY, 32'h0000_4180, handler entry PC on exception/interrupt
IM_LO, 32'h0000_3000, lowest legal fetch address
IM_HI, 32'h0000_4fff, highest legal fetch byte address
EXC_ADEL, 5'd4, ExcCode for a fetch address error
EXC_NULL, 5'd0, no-exception code

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard-unit stall; hold F and D registers
br_taken  input  1  branch/jump in D resolved taken
br_target  input  32  target PC for br_taken
eret_d  input  1  valid ERET instruction currently in D
epc  input  32  CP0 EPC, already forwarded, valid while eret_d=1
exc_req  input  1  CP0 takes an exception/interrupt this cycle (flush)
f_pc  output  32  current fetch PC, drives IM address
f_exc_code  output  5  combinational ExcCode of the current fetch
d_pc  output  32  PC of the instruction in D
d_exc_code  output  5  registered fetch ExcCode travelling with d_pc
d_valid  output  1  1 = D holds a real instruction, 0 = bubble

Behaviour:
- Reset (reset=1 at edge, any other inputs): f_pc<=PC_RESET; d_pc<=0; d_exc_code<=EXC_NULL; d_valid<=0. Reset has priority over everything.
- f_exc_code (combinational):
  - EXC_NULL if eret_d=1. This is the slot behind ERET; it is never executed.
  - Otherwise EXC_ADEL if f_pc<IM_LO, f_pc>IM_HI, or f_pc[1:0]!=0.
  - Otherwise EXC_NULL.
- Next-state priority at each edge: reset > exc_req > stall > eret_d > br_taken > sequential.
- exc_req=1, regardless of stall:
  - f_pc<=EXC_ENTRY.
  - d_valid<=0, d_exc_code<=EXC_NULL, d_pc<=0.
  - Any in-flight eret_d or br_taken is discarded.
- stall=1 (no exc_req): f_pc, d_pc, d_exc_code and d_valid all hold. eret_d may remain high across stall cycles. f_exc_code stays masked for every one of them.
- eret_d=1 (no stall, no exc_req):
  - f_pc<=epc.
  - D becomes a bubble: d_valid<=0, d_exc_code<=EXC_NULL. The slot after ERET is dropped; ERET has no delay slot.
- br_taken=1 (no stall, no exc_req, no eret_d):
  - f_pc<=br_target.
  - Delay-slot instruction advances normally: d_pc<=f_pc, d_exc_code<=f_exc_code, d_valid<=1.
- Sequential case: f_pc<=f_pc+4 (32-bit wrap, no saturation). d_pc<=f_pc, d_exc_code<=f_exc_code, d_valid<=1.
- Faulting fetch (AdEL):
  - The instruction still enters D with d_valid=1 and d_exc_code=EXC_ADEL.
  - The PC keeps advancing until CP0 raises exc_req.
- Misaligned or out-of-range epc/br_target: loaded as-is. It is flagged AdEL on the following fetch cycle.
- exc_req and eret_d together: exception wins; f_pc=EXC_ENTRY.
- Latency: every redirect is visible on f_pc exactly one cycle after the qualifying edge.

Test Plan:
1. Hold reset 2 cycles, release, run 3 cycles with no requests -> f_pc goes 0x3000, 0x3004, 0x3008, 0x300c; d_pc lags f_pc by one cycle; d_valid=1 from the first post-reset edge.
2. At f_pc=0x3010 assert br_taken, br_target=0x3100 -> next f_pc=0x3100; d_pc=0x3010 with d_valid=1 (delay slot kept); the cycle after, d_pc=0x3100.
3. Branch to 0x5000 -> f_exc_code=4 while f_pc=0x5000; next cycle d_exc_code=4, d_valid=1. Then assert exc_req -> f_pc=0x4180, d_valid=0.
4. eret_d=1, epc=0x3ffc, stall=1 for 2 cycles, f_pc=0x2ffc -> f_exc_code=0 throughout and all registers hold. Drop stall -> f_pc=0x3ffc, d_valid=0.
5. eret_d=1, br_taken=1, exc_req=1 in the same cycle with stall=1 -> f_pc=0x4180, d_valid=0.
6. f_pc=0x3002 via br_target -> f_exc_code=4. Assert reset mid-stall -> f_pc=0x3000, d_valid=0, d_exc_code=0 on the next edge.

Source files
------------

// File: rtl/f_pc_ctrl.sv
// Fetch-stage sequencer: owns the F-stage PC and the F/D boundary registers,
// selects the next fetch PC and flags fetch address errors (AdEL).
module f_pc_ctrl #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_4fff,
    parameter logic [4:0]  EXC_ADEL  = 5'd4,
    parameter logic [4:0]  EXC_NULL  = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        eret_d,
    input  logic [31:0] epc,
    input  logic        exc_req,
    output logic [31:0] f_pc,
    output logic [4:0]  f_exc_code,
    output logic [31:0] d_pc,
    output logic [4:0]  d_exc_code,
    output logic        d_valid
);

    localparam int unsigned PC_W = 32;

    logic addr_bad;

    // The slot fetched behind ERET is never executed, so its fault is masked.
    always_comb begin
        addr_bad   = (f_pc < IM_LO) || (f_pc > IM_HI) || (f_pc[1:0] != 2'b00);
        f_exc_code = EXC_NULL;
        if (!eret_d && addr_bad) begin
            f_exc_code = EXC_ADEL;
        end
    end

    // Priority: reset > exception flush > stall > ERET > branch > sequential.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc       <= PC_RESET;
            d_pc       <= '0;
            d_exc_code <= EXC_NULL;
            d_valid    <= 1'b0;
        end else if (exc_req) begin
            f_pc       <= EXC_ENTRY;
            d_pc       <= '0;
            d_exc_code <= EXC_NULL;
            d_valid    <= 1'b0;
        end else if (stall) begin
            f_pc       <= f_pc;
            d_pc       <= d_pc;
            d_exc_code <= d_exc_code;
            d_valid    <= d_valid;
        end else if (eret_d) begin
            // ERET has no delay slot: the wrong-path fetch becomes a bubble.
            f_pc       <= epc;
            d_pc       <= f_pc;
            d_exc_code <= EXC_NULL;
            d_valid    <= 1'b0;
        end else begin
            f_pc       <= br_taken ? br_target : f_pc + PC_W'(4);
            d_pc       <= f_pc;
            d_exc_code <= f_exc_code;
            d_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Directed, table-driven bench for the fetch-stage sequencer.
module tb_f_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, eret_d, exc_req;
    logic [31:0] br_target, epc;
    logic [31:0] f_pc, d_pc;
    logic [4:0]  f_exc_code, d_exc_code;
    logic        d_valid;

    int checks = 0;
    int errors = 0;

    f_pc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .eret_d     (eret_d),
        .epc        (epc),
        .exc_req    (exc_req),
        .f_pc       (f_pc),
        .f_exc_code (f_exc_code),
        .d_pc       (d_pc),
        .d_exc_code (d_exc_code),
        .d_valid    (d_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [31:0] bt;
        logic        er;
        logic [31:0] ep;
        logic        ex;
        logic        chk_fexc;
        logic [4:0]  e_fexc;
        logic [31:0] e_fpc;
        logic        chk_dpc;
        logic [31:0] e_dpc;
        logic [4:0]  e_dexc;
        logic        e_dv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, stl, br, input logic [31:0] bt,
                       input logic er, input logic [31:0] ep, input logic ex,
                       input logic chk_fexc, input logic [4:0] e_fexc,
                       input logic [31:0] e_fpc, input logic chk_dpc,
                       input logic [31:0] e_dpc, input logic [4:0] e_dexc,
                       input logic e_dv);
        vec_t v;
        v = '{rst, stl, br, bt, er, ep, ex, chk_fexc, e_fexc, e_fpc,
              chk_dpc, e_dpc, e_dexc, e_dv};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, stl, br, input logic [31:0] bt,
                         input logic er, input logic [31:0] ep, input logic ex);
        reset = rst; stall = stl; br_taken = br; br_target = bt;
        eret_d = er; epc = ep; exc_req = ex;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        //  rst stl br  bt            er  ep            ex  cfx fexc  f_pc          cdp d_pc          dexc  dv
        add(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 5'd0, 32'h0000_3000, 1, 32'h0,         5'd0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd0, 32'h0000_3000, 1, 32'h0,         5'd0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd0, 32'h0000_3004, 1, 32'h0000_3000, 5'd0, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd0, 32'h0000_3008, 1, 32'h0000_3004, 5'd0, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd0, 32'h0000_300c, 1, 32'h0000_3008, 5'd0, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd0, 32'h0000_3010, 1, 32'h0000_300c, 5'd0, 1);
        // taken branch keeps the delay slot
        add(0, 0, 1, 32'h0000_3100, 0, 32'h0,         0,  1, 5'd0, 32'h0000_3100, 1, 32'h0000_3010, 5'd0, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd0, 32'h0000_3104, 1, 32'h0000_3100, 5'd0, 1);
        // branch out of range: AdEL flows into D, then exception flush
        add(0, 0, 1, 32'h0000_5000, 0, 32'h0,         0,  1, 5'd0, 32'h0000_5000, 1, 32'h0000_3104, 5'd0, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd4, 32'h0000_5004, 1, 32'h0000_5000, 5'd4, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         1,  1, 5'd4, 32'h0000_4180, 1, 32'h0,         5'd0, 0);
        // ERET held by stall, wrong-path slot masked
        add(0, 0, 1, 32'h0000_2ffc, 0, 32'h0,         0,  1, 5'd0, 32'h0000_2ffc, 1, 32'h0000_4180, 5'd0, 1);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0,  1, 5'd4, 32'h0000_2ffc, 1, 32'h0000_4180, 5'd0, 1);
        add(0, 1, 0, 32'h0,         1, 32'h0000_3ffc, 0,  1, 5'd0, 32'h0000_2ffc, 1, 32'h0000_4180, 5'd0, 1);
        add(0, 1, 0, 32'h0,         1, 32'h0000_3ffc, 0,  1, 5'd0, 32'h0000_2ffc, 1, 32'h0000_4180, 5'd0, 1);
        add(0, 0, 0, 32'h0,         1, 32'h0000_3ffc, 0,  1, 5'd0, 32'h0000_3ffc, 0, 32'h0,         5'd0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd0, 32'h0000_4000, 1, 32'h0000_3ffc, 5'd0, 1);
        // exception beats stall, ERET and branch together
        add(0, 1, 1, 32'h0000_3100, 1, 32'h0000_3ffc, 1,  1, 5'd0, 32'h0000_4180, 1, 32'h0,         5'd0, 0);
        // misaligned target, reset during stall
        add(0, 0, 1, 32'h0000_3002, 0, 32'h0,         0,  1, 5'd0, 32'h0000_3002, 1, 32'h0000_4180, 5'd0, 1);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0,  1, 5'd4, 32'h0000_3002, 1, 32'h0000_4180, 5'd0, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0,         0,  1, 5'd4, 32'h0000_3000, 1, 32'h0,         5'd0, 0);
        // upper bound of IM window
        add(0, 0, 1, 32'h0000_4ffc, 0, 32'h0,         0,  1, 5'd0, 32'h0000_4ffc, 1, 32'h0000_3000, 5'd0, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd0, 32'h0000_5000, 1, 32'h0000_4ffc, 5'd0, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd4, 32'h0000_5004, 1, 32'h0000_5000, 5'd4, 1);
        // 32-bit wrap and below-window fetch
        add(0, 0, 1, 32'hffff_fffc, 0, 32'h0,         0,  1, 5'd4, 32'hffff_fffc, 1, 32'h0000_5004, 5'd4, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd4, 32'h0000_0000, 1, 32'hffff_fffc, 5'd4, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 5'd4, 32'h0000_0004, 1, 32'h0000_0000, 5'd4, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].bt,
                  vecs[i].er, vecs[i].ep, vecs[i].ex);
            #1;
            if (vecs[i].chk_fexc)
                chk($sformatf("v%0d f_exc_code", i), 32'(f_exc_code), 32'(vecs[i].e_fexc));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d f_pc", i), f_pc, vecs[i].e_fpc);
            if (vecs[i].chk_dpc)
                chk($sformatf("v%0d d_pc", i), d_pc, vecs[i].e_dpc);
            chk($sformatf("v%0d d_exc_code", i), 32'(d_exc_code), 32'(vecs[i].e_dexc));
            chk($sformatf("v%0d d_valid", i), 32'(d_valid), 32'(vecs[i].e_dv));
        end

        // Exception with ERET (no stall), then sequential fetch from the handler.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3abc, 1'b1);
        @(posedge clk);
        #1;
        chk("seq exc+eret f_pc", f_pc, 32'h0000_4180);
        chk("seq exc+eret d_valid", 32'(d_valid), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("seq handler f_pc %0d", k), f_pc, 32'h0000_4180 + 32'(4 * k));
            chk($sformatf("seq handler d_pc %0d", k), d_pc, 32'h0000_4180 + 32'(4 * (k - 1)));
            chk($sformatf("seq handler d_valid %0d", k), 32'(d_valid), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
